// File: rtl/alu_seq_unit.sv
// Registered ALU with a valid/ready handshake: 16 single-cycle base functions
// plus iterative unsigned multiply/divide (one bit per cycle).
module alu_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             alu_ext,
    input  logic [3:0]       alu_func,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             carry,
    output logic             zero,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       xop_q, xop_d;

    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_w;
    logic [WIDTH-1:0] base_y;
    logic             base_c;
    logic [WIDTH:0]   msum;
    logic [WIDTH:0]   dsh;
    logic [WIDTH:0]   ddiff;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;

    function automatic logic [WIDTH-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + {{(WIDTH-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    always_comb begin
        shamt  = B[SHW-1:0];
        add_w  = {1'b0, A} + {1'b0, B};
        base_y = '0;
        base_c = 1'b0;
        case (alu_func)
            4'h0: begin
                base_y = add_w[WIDTH-1:0];
                base_c = add_w[WIDTH];
            end
            4'h1: begin
                base_y = A - B;
                base_c = (A < B);
            end
            4'h2: base_y = ~A;
            4'h3: base_y = A << shamt;
            4'h4: base_y = A & B;
            4'h5: base_y = A | B;
            4'h6: base_y = A >> shamt;
            4'h7: base_y = $signed(A) >>> shamt;
            4'h8: base_y = A ^ B;
            4'h9: base_y = ~(A | B);
            4'hA: base_y = A + WIDTH'(1);
            4'hB: base_y = A - WIDTH'(1);
            4'hC: base_y = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            4'hD: base_y = {{(WIDTH-1){1'b0}}, $signed(A) > $signed(B)};
            4'hE: base_y = A << (WIDTH / 2);
            4'hF: base_y = popcnt(A);
        endcase
    end

    // hi/lo hold {product} for MUL and {remainder, quotient} for DIV
    always_comb begin
        msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        dsh   = {hi_q, lo_q[WIDTH-1]};
        ddiff = dsh - {1'b0, opnd_q};
        if (xop_q[1]) begin
            if (!ddiff[WIDTH]) begin
                hi_n = ddiff[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_n = dsh[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_n = msum[WIDTH:1];
            lo_n = {msum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        err_d   = err_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        xop_d   = xop_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = DONE;
                    carry_d = 1'b0;
                    err_d   = 1'b0;
                    if (!alu_ext) begin
                        y_d     = base_y;
                        carry_d = base_c;
                    end else if (alu_func[3:2] != 2'b00) begin
                        y_d   = '0;
                        err_d = 1'b1;
                    end else if (alu_func[1] && (B == '0)) begin
                        y_d   = alu_func[0] ? A : '1;
                        err_d = 1'b1;
                    end else begin
                        state_d = BUSY;
                        xop_d   = alu_func[1:0];
                        opnd_d  = alu_func[1] ? B : A;
                        lo_d    = alu_func[1] ? A : B;
                        hi_d    = '0;
                        cnt_d   = CW'(WIDTH);
                    end
                    zero_d = (y_d == '0);
                end
            end
            BUSY: begin
                hi_d  = hi_n;
                lo_d  = lo_n;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    y_d     = xop_q[0] ? hi_n : lo_n;
                    carry_d = 1'b0;
                    err_d   = 1'b0;
                    zero_d  = (y_d == '0);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            xop_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            xop_q   <= xop_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Y         = y_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign err       = err_q;

endmodule
